// File: rtl/piece_mover.sv
// Active tetromino controller: spawns the piece, applies edge-triggered left/right moves,
// steps it down on the gravity timer and emits a one-cycle lock mask when a drop is refused.
module piece_mover #(
  parameter int DROP_FRAMES = 30,
  parameter int SOFT_FRAMES = 3,
  parameter int SPAWN_COL   = 3
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         frame_clk_rise,
  input  logic [7:0]   keycode,
  input  logic         spawn,
  input  logic [15:0]  piece_mask,
  input  logic         bottomchecked,
  input  logic         leftchecked,
  input  logic         rightchecked,
  output logic [9:0]   Block_X_Pos,
  output logic [9:0]   Block_Y_Pos,
  output logic         is_currentstate,
  output logic         lock_valid,
  output logic [239:0] lock_cells,
  output logic         piece_active,
  output logic         game_over
);

  typedef enum logic [1:0] {IDLE = 2'd0, FALL = 2'd1, LOCK = 2'd2, OVER = 2'd3} state_t;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_SOFT  = 8'h16;
  localparam logic [3:0] COL_SPAWN = 4'(SPAWN_COL);
  localparam logic [9:0] X_RESET   = 10'(80 + 20 * SPAWN_COL);

  state_t         state_r, next_state_s;
  logic [3:0]     col_r, col_next_s;
  logic [4:0]     row_r, row_next_s;
  logic [4:0]     cnt_r, cnt_next_s, limit_s;
  logic           drop_pending_r, drop_next_s;
  logic [7:0]     key_prev_r;
  logic           key_edge_s;
  logic [9:0]     x_r, y_r, x_next_s, y_next_s;
  logic           lock_valid_r, lock_valid_next_s;
  logic [239:0]   lock_cells_r, lock_cells_next_s;
  logic           piece_active_r, piece_active_next_s;
  logic           game_over_r, game_over_next_s;

  // Cells outside the 10x24 field are clipped rather than wrapped.
  function automatic logic [239:0] lock_map(input logic [15:0] mask,
                                            input logic [3:0] col,
                                            input logic [4:0] row);
    logic [239:0] m;
    int cc, rr;
    m = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        cc = int'(col) + c;
        rr = int'(row) + r;
        if (mask[r*4+c] && (cc <= 32'sd9) && (rr <= 32'sd23)) begin
          m[rr*10+cc] = 1'b1;
        end
      end
    end
    return m;
  endfunction

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state, position and gravity decisions
  always_comb begin
    next_state_s = state_r;
    col_next_s   = col_r;
    row_next_s   = row_r;
    cnt_next_s   = cnt_r;
    drop_next_s  = drop_pending_r;
    key_edge_s   = (keycode != key_prev_r);
    limit_s      = (keycode == KEY_SOFT) ? 5'(SOFT_FRAMES) : 5'(DROP_FRAMES);
    case (state_r)
      IDLE: begin
        if (spawn) begin
          next_state_s = FALL;
          col_next_s   = COL_SPAWN;
          row_next_s   = 5'd0;
          cnt_next_s   = 5'd0;
          drop_next_s  = 1'b0;
        end else begin
          next_state_s = IDLE;
        end
      end
      FALL: begin
        if (key_edge_s && (keycode == KEY_LEFT) && leftchecked) begin
          col_next_s = col_r - 4'd1;
        end else if (key_edge_s && (keycode == KEY_RIGHT) && rightchecked) begin
          col_next_s = col_r + 4'd1;
        end else if (drop_pending_r) begin
          drop_next_s = 1'b0;
          if (bottomchecked) begin
            row_next_s = row_r + 5'd1;
          end else begin
            next_state_s = LOCK;
          end
        end else begin
          next_state_s = FALL;
        end
        // >= also catches a limit that shrank below the running count
        if (frame_clk_rise) begin
          if (cnt_r >= (limit_s - 5'd1)) begin
            cnt_next_s  = 5'd0;
            drop_next_s = 1'b1;
          end else begin
            cnt_next_s = cnt_r + 5'd1;
          end
        end else begin
          cnt_next_s = cnt_r;
        end
      end
      LOCK: begin
        if (row_r == 5'd0) begin
          next_state_s = OVER;
        end else begin
          next_state_s = IDLE;
        end
      end
      OVER:    next_state_s = OVER;
      default: next_state_s = IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the upcoming state
  always_comb begin
    x_next_s            = 10'd80 + 10'd20 * {6'd0, col_next_s};
    y_next_s            = 10'd20 * {5'd0, row_next_s};
    piece_active_next_s = (next_state_s == FALL);
    lock_valid_next_s   = (next_state_s == LOCK);
    game_over_next_s    = game_over_r | (next_state_s == OVER);
    if (next_state_s == LOCK) begin
      lock_cells_next_s = lock_map(piece_mask, col_r, row_r);
    end else begin
      lock_cells_next_s = '0;
    end
  end

  // Position, gravity and registered output storage
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      col_r          <= COL_SPAWN;
      row_r          <= 5'd0;
      cnt_r          <= 5'd0;
      drop_pending_r <= 1'b0;
      key_prev_r     <= 8'h00;
      x_r            <= X_RESET;
      y_r            <= 10'd0;
      lock_valid_r   <= 1'b0;
      lock_cells_r   <= '0;
      piece_active_r <= 1'b0;
      game_over_r    <= 1'b0;
    end else begin
      col_r          <= col_next_s;
      row_r          <= row_next_s;
      cnt_r          <= cnt_next_s;
      drop_pending_r <= drop_next_s;
      key_prev_r     <= keycode;
      x_r            <= x_next_s;
      y_r            <= y_next_s;
      lock_valid_r   <= lock_valid_next_s;
      lock_cells_r   <= lock_cells_next_s;
      piece_active_r <= piece_active_next_s;
      game_over_r    <= game_over_next_s;
    end
  end

  assign Block_X_Pos     = x_r;
  assign Block_Y_Pos     = y_r;
  assign is_currentstate = 1'b1;
  assign lock_valid      = lock_valid_r;
  assign lock_cells      = lock_cells_r;
  assign piece_active    = piece_active_r;
  assign game_over       = game_over_r;

endmodule

// File: tb/tb_piece_mover.sv
// Scoreboard bench: stimulus queues time-stamped expected output snapshots; a monitor
// compares every observed output change against the queue head.
module tb_piece_mover;

  typedef struct packed {
    logic [31:0]  stamp;
    logic [9:0]   x;
    logic [9:0]   y;
    logic         ic;
    logic         lv;
    logic [239:0] cells;
    logic         pa;
    logic         go;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         frame = 1'b0;
  logic [7:0]   keycode = 8'h00;
  logic         spawn = 1'b0;
  logic [15:0]  piece_mask = 16'h0000;
  logic         bottomchecked = 1'b0;
  logic         leftchecked = 1'b0;
  logic         rightchecked = 1'b0;
  logic [9:0]   x_pos, y_pos;
  logic         is_cur, lock_valid, piece_active, game_over;
  logic [239:0] lock_cells;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   have_prev = 1'b0;
  ev_t  prev;
  ev_t  m;
  ev_t  sb[$];
  logic [239:0] exp_cells;

  piece_mover dut (
    .Clk(clk), .Reset_n(rst_n), .frame_clk_rise(frame), .keycode(keycode),
    .spawn(spawn), .piece_mask(piece_mask), .bottomchecked(bottomchecked),
    .leftchecked(leftchecked), .rightchecked(rightchecked),
    .Block_X_Pos(x_pos), .Block_Y_Pos(y_pos), .is_currentstate(is_cur),
    .lock_valid(lock_valid), .lock_cells(lock_cells),
    .piece_active(piece_active), .game_over(game_over)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the observable outputs must match the next expectation.
  always @(negedge clk) begin
    ev_t cur, e;
    if (!mon_en) begin
      have_prev = 1'b0;
    end else begin
      cur = '{stamp: 32'd0, x: x_pos, y: y_pos, ic: is_cur, lv: lock_valid,
              cells: lock_cells, pa: piece_active, go: game_over};
      if (!have_prev || cur != prev) begin
        prev = cur;
        cur.stamp = 32'(cyc);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got t=%0d x=%0d y=%0d lv=%0b pa=%0b go=%0b, required no change",
                   cur.stamp, cur.x, cur.y, cur.lv, cur.pa, cur.go);
        end else begin
          e = sb.pop_front();
          if (e != cur) begin
            errors++;
            $display("FAIL event: got t=%0d x=%0d y=%0d ic=%0b lv=%0b pa=%0b go=%0b cells=%h required t=%0d x=%0d y=%0d ic=%0b lv=%0b pa=%0b go=%0b cells=%h",
                     cur.stamp, cur.x, cur.y, cur.ic, cur.lv, cur.pa, cur.go, cur.cells,
                     e.stamp, e.x, e.y, e.ic, e.lv, e.pa, e.go, e.cells);
          end
        end
      end
      have_prev = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int at);
    m.stamp = 32'(at);
    sb.push_back(m);
  endtask

  task automatic reset_model();
    m = '{stamp: 32'd0, x: 10'd140, y: 10'd0, ic: 1'b1, lv: 1'b0,
          cells: 240'd0, pa: 1'b0, go: 1'b0};
  endtask

  // n frame pulses on consecutive cycles; optionally the last one triggers a row step.
  task automatic ticks(input int n, input bit drop);
    for (int i = 0; i < n; i++) begin
      frame = 1'b1;
      if (drop && i == n - 1) begin
        m.y = m.y + 10'd20;
        push(cyc + 2);
      end
      tick();
    end
    frame = 1'b0;
  endtask

  initial begin
    int guard;
    reset_model();
    repeat (3) tick();
    rst_n = 1'b1;
    mon_en = 1'b1;
    push(cyc);
    tick();

    // Spawn
    spawn = 1'b1; m.pa = 1'b1; push(cyc + 1); tick();
    spawn = 1'b0; tick();

    // Held left key moves exactly once; refused left does nothing
    keycode = 8'h04; leftchecked = 1'b1; m.x = 10'd120; push(cyc + 1);
    repeat (10) tick();
    keycode = 8'h00; tick();
    leftchecked = 1'b0; keycode = 8'h04; repeat (3) tick();
    keycode = 8'h00; tick();

    // Normal gravity, then soft drop twice, then soft drop pressed mid-count
    bottomchecked = 1'b1;
    ticks(30, 1'b1); tick(); tick();
    keycode = 8'h16;
    ticks(3, 1'b1); tick();
    ticks(3, 1'b1); tick();
    keycode = 8'h00;
    ticks(10, 1'b0);
    keycode = 8'h16;
    ticks(1, 1'b1); tick(); tick();

    // Right edge in the same cycle drop_pending is high: move first, drop next
    keycode = 8'h00;
    ticks(30, 1'b0);
    keycode = 8'h07; rightchecked = 1'b1;
    m.x = 10'd140; push(cyc + 1);
    m.y = m.y + 10'd20; push(cyc + 2);
    tick();
    rightchecked = 1'b0; tick();
    keycode = 8'h16; tick();

    // Soft-drop to row 22
    repeat (17) begin
      ticks(3, 1'b1); tick();
    end

    // Lock at col 3 row 22; third mask row falls below the field and is clipped
    piece_mask = 16'h0333; bottomchecked = 1'b0;
    exp_cells = '0;
    exp_cells[223] = 1'b1; exp_cells[224] = 1'b1;
    exp_cells[233] = 1'b1; exp_cells[234] = 1'b1;
    frame = 1'b1; tick(); tick();
    m.lv = 1'b1; m.pa = 1'b0; m.cells = exp_cells; push(cyc + 2);
    m.lv = 1'b0; m.cells = '0; push(cyc + 3);
    tick(); frame = 1'b0;
    tick();
    spawn = 1'b1; tick();
    spawn = 1'b0; repeat (3) tick();

    // Spawn and lock on row 0: game over
    spawn = 1'b1; m.pa = 1'b1; m.y = 10'd0; push(cyc + 1); tick();
    spawn = 1'b0;
    piece_mask = 16'h000F;
    exp_cells = '0;
    exp_cells[3] = 1'b1; exp_cells[4] = 1'b1; exp_cells[5] = 1'b1; exp_cells[6] = 1'b1;
    frame = 1'b1; tick(); tick();
    m.lv = 1'b1; m.pa = 1'b0; m.cells = exp_cells; push(cyc + 2);
    m.lv = 1'b0; m.cells = '0; m.go = 1'b1; push(cyc + 3);
    tick(); frame = 1'b0;
    repeat (3) tick();
    spawn = 1'b1; tick(); spawn = 1'b0;
    keycode = 8'h04; leftchecked = 1'b1; repeat (4) tick();

    // Reset clears game over; a fresh spawn is accepted
    mon_en = 1'b0; rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1; reset_model(); mon_en = 1'b1; push(cyc);
    tick();
    spawn = 1'b1; m.pa = 1'b1; push(cyc + 1); tick();
    spawn = 1'b0; repeat (3) tick();

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending events, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piece_mover.md
# piece_mover

Controls the active falling tetromino on the 10×24 playfield: spawns it, shifts it left/right on keypresses, and drops it one row per gravity period. It drives the piece position into the saved-boundary checker and acts on the returned `bottomchecked`/`leftchecked`/`rightchecked` permissions in the following cycle's decision. When a drop is refused, it emits a one-cycle lock mask that the playfield register ORs into `savedblocks`.

## Interface
- `DROP_FRAMES`, default 30: frame ticks per gravity step.
- `SOFT_FRAMES`, default 3: frame ticks per step while the soft-drop key is held.
- `SPAWN_COL`, default 3: column of the piece's top-left cell at spawn (0..9).

Ports:
- `Clk` in 1: system clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `frame_clk_rise` in 1: one-cycle pulse per video frame.
- `keycode` in 8: current key. 0x04 = left, 0x07 = right, 0x16 = soft drop.
- `spawn` in 1: pulse that requests a new piece.
- `piece_mask` in 16: 4×4 occupancy of the current piece. Bit `r*4+c` is row r, column c.
- `bottomchecked`, `leftchecked`, `rightchecked` in 1 each: checker permissions for the current position.
- `Block_X_Pos`, `Block_Y_Pos` out 10 each: top-left pixel of the piece.
- `is_currentstate` out 1: tied to 1.
- `lock_valid` out 1: lock pulse.
- `lock_cells` out 240: cells to set. Bit index is `row*10+col`.
- `piece_active` out 1: high in FALL.
- `game_over` out 1: sticky.

## Operation
- Position is held internally as cell coordinates: `col` (4 bits) and `row` (5 bits).
  - `Block_X_Pos = 80 + 20*col`.
  - `Block_Y_Pos = 20*row`.
  - Outputs are registered and zero-extended to 10 bits.
- States: IDLE, FALL, LOCK, OVER.
  - IDLE: on `spawn`, set `col=SPAWN_COL`, `row=0`, clear the frame counter and `drop_pending`, go to FALL.
  - FALL: each cycle, evaluate in priority order:
    1. Key edge left with `leftchecked=1`: `col-1`.
    2. Key edge right with `rightchecked=1`: `col+1`.
    3. Otherwise, if `drop_pending`:
       - `bottomchecked=1`: `row+1`, clear `drop_pending`.
       - `bottomchecked=0`: go to LOCK, clear `drop_pending`.
    - A refused horizontal move is consumed; it is not retried.
    - `spawn` is ignored.
  - LOCK: for one cycle, `lock_valid=1` and `lock_cells` holds the bits for every set `piece_mask` bit at `(row+r)*10 + (col+c)`.
    - Cells with `col+c>9` or `row+r>23` are dropped.
    - If `row==0`, go to OVER and set `game_over=1`. Otherwise go to IDLE.
  - OVER: absorbing until reset. No moves, no locks, `spawn` ignored.
- Key edge: registered `key_prev` updates every cycle in every state.
  - A move key fires only when `keycode != key_prev`. Holding a key moves the piece once.
  - Edges that occur outside FALL are discarded.
- Gravity counter (5 bits):
  - Increments on `frame_clk_rise` in FALL only.
  - When the count reaches its limit minus 1, it clears and sets `drop_pending`. The limit is `SOFT_FRAMES` if `keycode==0x16`, else `DROP_FRAMES`.
  - If the limit drops below the current count (soft drop pressed mid-count), the counter clears and `drop_pending` is set on the next tick.
- Simultaneous events: a horizontal edge and `drop_pending` in the same cycle resolve as horizontal first. The drop is evaluated on the next cycle against the refreshed checker flags.
- `lock_cells` is 0 in every state except LOCK.

## Timing
- Reset values:
  - state IDLE, `col=SPAWN_COL`, `row=0`.
  - `Block_X_Pos = 80+20*SPAWN_COL` (140 with defaults), `Block_Y_Pos=0`.
  - `lock_valid=0`, `lock_cells=0`, `piece_active=0`, `game_over=0`.
  - Counter, `drop_pending`, and `key_prev` cleared.
- `Reset_n` low mid-operation aborts any fall or lock immediately. No partial `lock_valid` is issued.
- Key edge in cycle n: the new position is visible at n+1. Checker flags are valid combinationally at n+1, so the next decision is made at n+1.
- Gravity: the final `frame_clk_rise` in cycle n sets `drop_pending` at n+1. The row changes at n+2 if no horizontal edge occurs at n+1.
- Lock: the refused drop is decided in cycle n. `lock_valid` is high in cycle n+1 only. The state is IDLE or OVER at n+2.
- `piece_active` drops the same cycle LOCK is entered.
- `spawn` in the same cycle as `lock_valid` is ignored. The earliest accepted spawn is the cycle after the lock pulse.

## Test plan
- **Reset and spawn:** reset, then `spawn` pulse.
  - Response: X=140, Y=0, `piece_active=1` one cycle later.
- **Left move:** `keycode` 0x00→0x04 held for 10 cycles with `leftchecked=1`.
  - Response: X 140→120 exactly once.
  - Then 0x04→0x00→0x04 with `leftchecked=0`: X stays 120.
- **Gravity:** 30 `frame_clk_rise` pulses with `bottomchecked=1`.
  - Response: Y 0→20 two cycles after the 30th pulse.
  - With `keycode=0x16`: a step every 3 pulses.
- **Simultaneous move and drop:** right edge in the same cycle `drop_pending` is high.
  - Response: X+20 first, then Y+20 on the following cycle.
- **Lock mid-field:** O-piece mask 0x0033 at col 3, row 22, `bottomchecked=0`.
  - Response: one-cycle `lock_valid` with bits 223, 224, 233, 234 set, then IDLE.
- **Game over:** `bottomchecked=0` at row 0 with mask 0x000F at col 3.
  - Response: `lock_cells` bits 3–6, `game_over=1` sticky; subsequent `spawn` ignored until `Reset_n` low.
